// File: rtl/demux_1x2_stage.sv
// rtl/demux_1x2_stage.sv - registered 1-to-2 stream demultiplexer with 2-entry output buffers
//
// demux_1x2_buf
//   Two-entry FIFO used once per output. The head entry and the valid/count
//   flags come straight from registers. Only the write side is fed by logic
//   outside the buffer.
//   clk, rst       clock, asynchronous active-high reset
//   flush          synchronous clear of count and pointers; storage is left stale
//   wr_en/wr_data  push one word at the tail
//   rd_ready       consumer accepts the head word
//   rd_data        head word
//   rd_valid       buffer non-empty
//   count          occupancy, 0..2
//   full           count == 2
//
// demux_1x2_stage
//   Steers each accepted input word to out0 or out1 according to in_sel.
//   in_ready depends only on rst, flush, in_sel and registered occupancy.
//   It has no path from either out*_ready, so no ready-to-ready path exists.
//   clk, rst, flush                  clock, async reset, synchronous flush
//   in_data/in_sel/in_valid/in_ready input stream and destination select
//   out0_* / out1_*                  data/valid/ready/count per consumer

module demux_1x2_buf #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [1:0]       count,
    output logic             full
);

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             pop;

    assign rd_valid = (count_q != 2'd0);
    assign full     = (count_q == 2'd2);
    assign count    = count_q;
    assign rd_data  = mem_q[rd_ptr_q];
    assign pop      = rd_valid & rd_ready;

    always_comb begin
        mem_d[0] = mem_q[0];
        mem_d[1] = mem_q[1];
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            // Flush drops every buffered word and any same-cycle push or pop.
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (wr_en) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({wr_en, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

module demux_1x2_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [1:0]       out0_count,
    output logic [1:0]       out1_count
);

    logic full0;
    logic full1;
    logic sel_full;
    logic push;
    logic push0;
    logic push1;

    // Readiness is judged against the buffer the current word is aimed at only.
    // in_sel is a don't-care unless a push actually happens.
    assign sel_full = in_sel ? full1 : full0;
    assign in_ready = ~rst & ~flush & ~sel_full;
    assign push     = in_valid & in_ready;
    assign push0    = push & ~in_sel;
    assign push1    = push &  in_sel;

    demux_1x2_buf #(.WIDTH(WIDTH)) u_buf0 (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .wr_en    (push0),
        .wr_data  (in_data),
        .rd_ready (out0_ready),
        .rd_data  (out0_data),
        .rd_valid (out0_valid),
        .count    (out0_count),
        .full     (full0)
    );

    demux_1x2_buf #(.WIDTH(WIDTH)) u_buf1 (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .wr_en    (push1),
        .wr_data  (in_data),
        .rd_ready (out1_ready),
        .rd_data  (out1_data),
        .rd_valid (out1_valid),
        .count    (out1_count),
        .full     (full1)
    );

endmodule

// File: tb/tb_demux_1x2_stage.sv
// tb/tb_demux_1x2_stage.sv - self-checking bench for demux_1x2_stage

module tb_demux_1x2_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [31:0] in_data;
    logic        in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out0_data;
    logic        out0_valid;
    logic        out0_ready;
    logic [31:0] out1_data;
    logic        out1_valid;
    logic        out1_ready;
    logic [1:0]  out0_count;
    logic [1:0]  out1_count;

    int n_tests = 0;
    int n_fail  = 0;

    demux_1x2_stage #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out0_count (out0_count),
        .out1_count (out1_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs for one cycle plus the outputs expected just before that cycle's edge.
    typedef struct packed {
        logic        rst;
        logic        flush;
        logic        sel;
        logic        valid;
        logic [31:0] din;
        logic        r0;
        logic        r1;
        logic        e_ir;
        logic        e_v0;
        logic [31:0] e_d0;
        logic [1:0]  e_c0;
        logic        e_v1;
        logic [31:0] e_d1;
        logic [1:0]  e_c1;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic f, input logic s, input logic v,
                                input logic [31:0] d, input logic r0, input logic r1,
                                input logic ir, input logic v0, input logic [31:0] d0,
                                input logic [1:0] c0, input logic v1, input logic [31:0] d1,
                                input logic [1:0] c1);
        vec_t t;
        t.rst = r; t.flush = f; t.sel = s; t.valid = v; t.din = d; t.r0 = r0; t.r1 = r1;
        t.e_ir = ir; t.e_v0 = v0; t.e_d0 = d0; t.e_c0 = c0;
        t.e_v1 = v1; t.e_d1 = d1; t.e_c1 = c1;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic s, input logic v,
                         input logic [31:0] d, input logic r0, input logic r1);
        rst = r; flush = f; in_sel = s; in_valid = v; in_data = d;
        out0_ready = r0; out1_ready = r1;
    endtask

    logic [31:0] q0[$];
    logic [31:0] q1[$];

    initial begin
        int pushed;
        int cycles;
        bit exp_ir;
        bit do_push;

        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_v0", 32'(out0_valid), 32'd0);
        chk("rst_c1", 32'(out1_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // rst flush sel val din r0 r1 | ir v0 d0 c0 v1 d1 c1
        vecs.push_back(mk(0,0,0,1,32'h11,0,0, 1,0,32'h0,0, 0,32'h0,0));
        // reset mid-stream: word 0x11 is lost, outputs zero immediately
        vecs.push_back(mk(1,0,1,1,32'h22,0,0, 0,0,32'h0,0, 0,32'h0,0));
        vecs.push_back(mk(0,0,0,0,32'h0,1,1, 1,0,32'h0,0, 0,32'h0,0));
        // steering
        vecs.push_back(mk(0,0,0,1,32'hDEADBEEF,1,1, 1,0,32'h0,0, 0,32'h0,0));
        vecs.push_back(mk(0,0,1,1,32'h12345678,1,1, 1,1,32'hDEADBEEF,1, 0,32'h0,0));
        vecs.push_back(mk(0,0,0,0,32'h0,1,1, 1,0,32'h0,0, 1,32'h12345678,1));
        vecs.push_back(mk(0,0,0,0,32'h0,0,0, 1,0,32'h0,0, 0,32'h0,0));
        // backpressure / full
        vecs.push_back(mk(0,0,0,1,32'h1,0,0, 1,0,32'h0,0, 0,32'h0,0));
        vecs.push_back(mk(0,0,0,1,32'h2,0,0, 1,1,32'h1,1, 0,32'h0,0));
        vecs.push_back(mk(0,0,0,1,32'h3,0,0, 0,1,32'h1,2, 0,32'h0,0));
        vecs.push_back(mk(0,0,1,0,32'h3,0,0, 1,1,32'h1,2, 0,32'h0,0));
        vecs.push_back(mk(0,0,0,1,32'h3,1,0, 0,1,32'h1,2, 0,32'h0,0));
        vecs.push_back(mk(0,0,0,1,32'h3,1,0, 1,1,32'h2,1, 0,32'h0,0));
        vecs.push_back(mk(0,0,0,0,32'h0,1,0, 1,1,32'h3,1, 0,32'h0,0));
        vecs.push_back(mk(0,0,0,0,32'h0,0,0, 1,0,32'h0,0, 0,32'h0,0));
        // fill both buffers, then flush with a live input word
        vecs.push_back(mk(0,0,0,1,32'hB0,0,0, 1,0,32'h0,0, 0,32'h0,0));
        vecs.push_back(mk(0,0,0,1,32'hB1,0,0, 1,1,32'hB0,1, 0,32'h0,0));
        vecs.push_back(mk(0,0,1,1,32'hC0,0,0, 1,1,32'hB0,2, 0,32'h0,0));
        vecs.push_back(mk(0,0,1,1,32'hC1,0,0, 1,1,32'hB0,2, 1,32'hC0,1));
        vecs.push_back(mk(0,1,0,1,32'hEE,1,1, 0,1,32'hB0,2, 1,32'hC0,2));
        vecs.push_back(mk(0,0,0,0,32'h0,0,0, 1,0,32'h0,0, 0,32'h0,0));
        vecs.push_back(mk(0,0,1,0,32'h0,0,0, 1,0,32'h0,0, 0,32'h0,0));

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].flush, vecs[i].sel, vecs[i].valid, vecs[i].din,
                  vecs[i].r0, vecs[i].r1);
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
            chk($sformatf("v%0d_v0", i), 32'(out0_valid), 32'(vecs[i].e_v0));
            chk($sformatf("v%0d_c0", i), 32'(out0_count), 32'(vecs[i].e_c0));
            chk($sformatf("v%0d_v1", i), 32'(out1_valid), 32'(vecs[i].e_v1));
            chk($sformatf("v%0d_c1", i), 32'(out1_count), 32'(vecs[i].e_c1));
            if (vecs[i].e_v0 || vecs[i].rst)
                chk($sformatf("v%0d_d0", i), out0_data, vecs[i].e_d0);
            if (vecs[i].e_v1 || vecs[i].rst)
                chk($sformatf("v%0d_d1", i), out1_data, vecs[i].e_d1);
        end

        // streaming push+pop at count=1: one word per cycle, in order
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hA0 + 32'(i), 1'b1, 1'b0);
            #1;
            chk("stream_in_ready", 32'(in_ready), 32'd1);
            if (i == 0) begin
                chk("stream_c0_first", 32'(out0_count), 32'd0);
            end else begin
                chk("stream_v0", 32'(out0_valid), 32'd1);
                chk("stream_c0", 32'(out0_count), 32'd1);
                chk("stream_d0", out0_data, 32'hA0 + 32'(i - 1));
            end
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        #1;
        chk("stream_last_d0", out0_data, 32'hAF);
        chk("stream_last_c0", 32'(out0_count), 32'd1);
        @(negedge clk);
        #1;
        chk("stream_drained_c0", 32'(out0_count), 32'd0);

        // random traffic against per-channel queue scoreboard
        pushed = 0;
        cycles = 0;
        while (pushed < 2000 && cycles < 20000) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                  $urandom, ($urandom_range(0, 4) < 3), ($urandom_range(0, 4) < 3));
            #1;
            exp_ir = in_sel ? (q1.size() != 2) : (q0.size() != 2);
            chk("rnd_in_ready", 32'(in_ready), 32'(exp_ir));
            chk("rnd_c0", 32'(out0_count), 32'(q0.size()));
            chk("rnd_c1", 32'(out1_count), 32'(q1.size()));
            chk("rnd_c0_le2", 32'(out0_count <= 2'd2), 32'd1);
            chk("rnd_c1_le2", 32'(out1_count <= 2'd2), 32'd1);
            chk("rnd_v0", 32'(out0_valid), 32'(q0.size() != 0));
            chk("rnd_v1", 32'(out1_valid), 32'(q1.size() != 0));
            if (q0.size() != 0) chk("rnd_d0", out0_data, q0[0]);
            if (q1.size() != 0) chk("rnd_d1", out1_data, q1[0]);
            do_push = in_valid && exp_ir;
            if (q0.size() != 0 && out0_ready) void'(q0.pop_front());
            if (q1.size() != 0 && out1_ready) void'(q1.pop_front());
            if (do_push) begin
                if (in_sel) q1.push_back(in_data);
                else        q0.push_back(in_data);
                pushed++;
            end
            cycles++;
        end
        chk("rnd_budget", 32'(pushed), 32'd2000);

        // drain; both buffers must empty with the remaining words in order
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
            #1;
            if (q0.size() != 0) chk("drain_d0", out0_data, q0[0]);
            if (q1.size() != 0) chk("drain_d1", out1_data, q1[0]);
            if (q0.size() != 0) void'(q0.pop_front());
            if (q1.size() != 0) void'(q1.pop_front());
        end
        @(negedge clk);
        #1;
        chk("drain_c0", 32'(out0_count), 32'd0);
        chk("drain_c1", 32'(out1_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
